nf_key_debounce: RTL and testbench

//  Input-side counterpart to the seven-segment output path: samples raw board push-keys,

---
 rtl/nf_key_debounce_if.sv | 27 ++
 rtl/nf_key_debounce.sv | 186 ++++++++++++++++++
 tb/tb_nf_key_debounce.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf_key_debounce_if.sv
// Key-pin bundle between the board pins (master side) and nf_key_debounce (slave side).
// key_raw is asynchronous; every other signal is a registered, clk-synchronous output.
interface nf_key_debounce_if #(
  parameter int KEY_N = 4
);
  logic [KEY_N-1:0] key_raw;
  logic [KEY_N-1:0] key_level;
  logic [KEY_N-1:0] key_press;
  logic [KEY_N-1:0] key_release;
  logic [KEY_N-1:0] key_toggle;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_toggle
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_toggle
  );
endinterface

// File: rtl/nf_key_debounce.sv
// Per-key 2-flop synchroniser + UP/WAIT_DN/DOWN/WAIT_UP debounce FSM with level, edge and toggle outputs.
// Optional auto-repeat of key_press while held is enabled by defining NF_KEY_AUTOREPEAT_EN.
module nf_key_debounce #(
  parameter int KEY_N         = 4,
  parameter int CNT_W         = 20,
  parameter int DB_CYCLES     = 500000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic               clk,
  input  logic               resetn,
  nf_key_debounce_if.slave   key_if,
  output logic [2*KEY_N-1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_UP      = 2'd0,
    ST_WAIT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_WAIT_UP = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [KEY_N-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  if (KEY_N < 1 || KEY_N > 8 || DB_CYCLES < 2 || DB_CYCLES > (2**CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("nf_key_debounce: parameter out of range");
  end

  logic [KEY_N-1:0] sync1_q, sync2_q, s;
  state_e           state_q [KEY_N];
  state_e           state_d [KEY_N];
  logic [CNT_W-1:0] cnt_q   [KEY_N];
  logic [CNT_W-1:0] cnt_d   [KEY_N];
  logic [KEY_N-1:0] press_ev, rel_ev, level_d, rpt_pulse;
  logic [KEY_N-1:0] level_q, press_q, release_q, toggle_q;

  // Sync flops reset to the released pin level so reset release never looks like a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= key_if.key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < KEY_N; k++) begin
        state_q[k] <= ST_UP;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < KEY_N; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always_comb begin
    press_ev = '0;
    rel_ev   = '0;
    level_d  = '0;
    for (int k = 0; k < KEY_N; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        ST_UP: begin
          if (s[k]) begin
            state_d[k] = ST_WAIT_DN;
            cnt_d[k]   = '0;
          end
        end
        ST_WAIT_DN: begin
          if (!s[k]) begin
            state_d[k] = ST_UP;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_MAX) begin
            state_d[k] = ST_DOWN;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k]   = cnt_q[k] + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (!s[k]) begin
            state_d[k] = ST_WAIT_UP;
            cnt_d[k]   = '0;
          end
        end
        ST_WAIT_UP: begin
          if (s[k]) begin
            state_d[k] = ST_DOWN;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_MAX) begin
            state_d[k] = ST_UP;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k]   = cnt_q[k] + CNT_W'(1);
          end
        end
        default: begin
          state_d[k] = ST_UP;
          cnt_d[k]   = '0;
        end
      endcase
      // A bounce back from WAIT_UP to DOWN is not a new press: only WAIT_DN->DOWN counts.
      press_ev[k] = (state_q[k] == ST_WAIT_DN) && (state_d[k] == ST_DOWN);
      rel_ev[k]   = (state_q[k] == ST_WAIT_UP) && (state_d[k] == ST_UP);
      level_d[k]  = (state_d[k] == ST_DOWN) || (state_d[k] == ST_WAIT_UP);
    end
  end

`ifdef NF_KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q [KEY_N];
  logic [RPT_W-1:0] rpt_cnt_d [KEY_N];
  logic [KEY_N-1:0] rpt_first_q, rpt_first_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < KEY_N; k++) rpt_cnt_q[k] <= '0;
      rpt_first_q <= '1;
    end else begin
      for (int k = 0; k < KEY_N; k++) rpt_cnt_q[k] <= rpt_cnt_d[k];
      rpt_first_q <= rpt_first_d;
    end
  end

  // Counter only runs while DOWN persists; any excursion restarts the initial delay.
  always_comb begin
    rpt_pulse   = '0;
    rpt_first_d = '1;
    for (int k = 0; k < KEY_N; k++) begin
      rpt_cnt_d[k] = '0;
      if (state_q[k] == ST_DOWN && state_d[k] == ST_DOWN) begin
        if (rpt_cnt_q[k] == (rpt_first_q[k] ? RPT_DLY_LAST : RPT_PER_LAST)) begin
          rpt_pulse[k]   = 1'b1;
          rpt_first_d[k] = 1'b0;
        end else begin
          rpt_cnt_d[k]   = rpt_cnt_q[k] + RPT_W'(1);
          rpt_first_d[k] = rpt_first_q[k];
        end
      end
    end
  end
`else
  assign rpt_pulse = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_ev | rpt_pulse;
      release_q <= rel_ev;
      toggle_q  <= toggle_q ^ press_ev;
    end
  end

  assign key_if.key_level   = level_q;
  assign key_if.key_press   = press_q;
  assign key_if.key_release = release_q;
  assign key_if.key_toggle  = toggle_q;

  always_comb begin
    dbg_state_o = '0;
    for (int k = 0; k < KEY_N; k++) dbg_state_o[2*k +: 2] = state_q[k];
  end

endmodule

// File: tb/tb_nf_key_debounce.sv
// Directed bench for nf_key_debounce with DB_CYCLES=4, active-low keys, repeat 20/8.
module tb_nf_key_debounce;
  localparam int KEY_N = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [2*KEY_N-1:0] dbg_state;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  nf_key_debounce_if #(.KEY_N(KEY_N)) kif ();

  nf_key_debounce #(
    .KEY_N(KEY_N), .CNT_W(8), .DB_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_if      (kif.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    kif.key_raw = '1;
    resetn = 1'b0;
    cyc(2);
    checks++;
    if ({kif.key_level, kif.key_press, kif.key_release, kif.key_toggle} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {kif.key_level, kif.key_press, kif.key_release, kif.key_toggle});
    end
    checks++;
    if (dbg_state !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got %h expected 00", dbg_state);
    end
    resetn = 1'b1;
    cyc(10);
    checks++;
    if ({kif.key_level, kif.key_press, kif.key_toggle} !== 12'h0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 000",
               {kif.key_level, kif.key_press, kif.key_toggle});
    end
  endtask

  task automatic test_glitch();
    logic [KEY_N-1:0] act = '0;
    kif.key_raw[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      act |= kif.key_level | kif.key_press | kif.key_release;
    end
    kif.key_raw[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      act |= kif.key_level | kif.key_press | kif.key_release;
    end
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_activity: got %b expected 0000", act);
    end
  endtask

  task automatic test_press();
    int press_cnt = 0;
    int press_at = 0;
    logic lvl6 = 1'bx;
    kif.key_raw[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (kif.key_press[0]) begin
        press_cnt++;
        press_at = i;
      end
      if (i == 6) lvl6 = kif.key_level[0];
    end
    checks++;
    if (press_cnt != 1) begin
      errors++;
      $display("FAIL press_count: got %0d expected 1", press_cnt);
    end
    checks++;
    if (press_at != 7) begin
      errors++;
      $display("FAIL press_edge: got %0d expected 7", press_at);
    end
    checks++;
    if (lvl6 !== 1'b0) begin
      errors++;
      $display("FAIL press_level_early: got %b expected 0", lvl6);
    end
    checks++;
    if ({kif.key_level, kif.key_toggle} !== 8'b0001_0001) begin
      errors++;
      $display("FAIL press_level_toggle: got %b expected 00010001", {kif.key_level, kif.key_toggle});
    end
    checks++;
    if (dbg_state[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL press_state: got %0d expected 2", dbg_state[1:0]);
    end
  endtask

  task automatic test_release();
    int rel_cnt = 0;
    int rel_at = 0;
    int press_cnt = 0;
    kif.key_raw[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (kif.key_release[0]) begin
        rel_cnt++;
        rel_at = i;
      end
      if (kif.key_press[0]) press_cnt++;
    end
    checks++;
    if (rel_cnt != 1 || rel_at != 7) begin
      errors++;
      $display("FAIL release_pulse: got count %0d at %0d expected 1 at 7", rel_cnt, rel_at);
    end
    checks++;
    if (press_cnt != 0) begin
      errors++;
      $display("FAIL release_no_press: got %0d expected 0", press_cnt);
    end
    checks++;
    if ({kif.key_level, kif.key_toggle} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL release_level_toggle: got %b expected 00000001", {kif.key_level, kif.key_toggle});
    end
  endtask

  task automatic test_simultaneous();
    logic [KEY_N-1:0] first_press = '0;
    logic [KEY_N-1:0] rel_seen = '0;
    int first_at = 0;
    kif.key_raw = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (first_at == 0 && kif.key_press != 4'b0000) begin
        first_at = i;
        first_press = kif.key_press;
      end
    end
    checks++;
    if (first_press !== 4'b1111 || first_at != 7) begin
      errors++;
      $display("FAIL simul_press: got %b at %0d expected 1111 at 7", first_press, first_at);
    end
    checks++;
    if (kif.key_toggle !== 4'b1110) begin
      errors++;
      $display("FAIL simul_toggle: got %b expected 1110", kif.key_toggle);
    end
    // one-sample high glitch on key 2 while it is DOWN
    kif.key_raw[2] = 1'b1;
    cyc(1);
    kif.key_raw[2] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      rel_seen |= kif.key_release;
    end
    checks++;
    if (rel_seen !== 4'b0000 || kif.key_level !== 4'b1111) begin
      errors++;
      $display("FAIL bounce_in_down: got release %b level %b expected 0000 1111", rel_seen, kif.key_level);
    end
    kif.key_raw = 4'b1111;
    cyc(12);
    checks++;
    if (kif.key_level !== 4'b0000) begin
      errors++;
      $display("FAIL simul_release_level: got %b expected 0000", kif.key_level);
    end
  endtask

  task automatic test_reset_mid();
    int press_at = 0;
    kif.key_raw[1] = 1'b0;
    cyc(3);
    resetn = 1'b0;
    #1;
    checks++;
    if ({kif.key_level, kif.key_press, kif.key_release, kif.key_toggle} !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0000",
               {kif.key_level, kif.key_press, kif.key_release, kif.key_toggle});
    end
    cyc(2);
    checks++;
    if ({kif.key_level, kif.key_press, kif.key_toggle} !== 12'h0 || dbg_state !== 8'h00) begin
      errors++;
      $display("FAIL midreset_hold: got %h state %h expected 000 00",
               {kif.key_level, kif.key_press, kif.key_toggle}, dbg_state);
    end
    resetn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (press_at == 0 && kif.key_press[1]) press_at = i;
    end
    checks++;
    if (press_at != 7) begin
      errors++;
      $display("FAIL midreset_press_edge: got %0d expected 7", press_at);
    end
    checks++;
    if (kif.key_level !== 4'b0010 || kif.key_toggle !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_level_toggle: got %b %b expected 0010 0010", kif.key_level, kif.key_toggle);
    end
    kif.key_raw[1] = 1'b1;
    cyc(12);
  endtask

  // Hold key 0 for 60 cycles; collect every press pulse cycle against the expected list.
  task automatic test_hold();
    int rel_at = 0;
    int got_n = 0;
    exp_q.delete();
`ifdef NF_KEY_AUTOREPEAT_EN
    exp_q = '{32'd7, 32'd27, 32'd35, 32'd43, 32'd51, 32'd59};
`else
    exp_q = '{32'd7};
`endif
    kif.key_raw[0] = 1'b0;
    for (int i = 1; i <= 75; i++) begin
      if (i == 61) kif.key_raw[0] = 1'b1;
      cyc(1);
      if (kif.key_press[0]) begin
        got_n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL hold_extra_press: got pulse at %0d expected none", i);
        end else if (exp_q.pop_front() != 32'(i)) begin
          errors++;
          $display("FAIL hold_press_cycle: got pulse at %0d expected different cycle", i);
        end
      end
      if (rel_at == 0 && kif.key_release[0]) rel_at = i;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_missing_press: got %0d pulses, %0d expected pulses missing", got_n, exp_q.size());
    end
    checks++;
    if (kif.key_toggle[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_toggle: got %b expected 1", kif.key_toggle[0]);
    end
    checks++;
    if (rel_at != 67) begin
      errors++;
      $display("FAIL hold_release_edge: got %0d expected 67", rel_at);
    end
  endtask

  initial begin
    kif.key_raw = '1;
    test_reset();
    test_glitch();
    test_press();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
